inst_fetch_unit: RTL

Byte-serial instruction fetch stage for the MCU51 core. It sits directly downstream of the byte-wide program ROM and drives its address and active-low chip select. It assembles 1–3-byte MCS-51 instructions from the returned bytes and presents each whole instruction, with its PC and length, to the decoder over a valid/ready handshake. It also accepts PC redirects from the execute stage.

---
 rtl/mcu51_pkg.sv | 74 +++++++
 rtl/inst_len_dec.sv | 13 +
 rtl/inst_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared types and constants for the MCU51 front end.
//   asm_state_e : instruction assembly state (opcode / second byte / third byte)
//   OP_LJMP, OP_SJMP : opcodes the fetch stage may follow
//   op_len()    : MCS-51 instruction length (1..3) for every opcode
package mcu51_pkg;

  typedef enum logic [1:0] {
    S_OP = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } asm_state_e;

  localparam logic [7:0] OP_LJMP = 8'h02;
  localparam logic [7:0] OP_SJMP = 8'h80;

  // The opcode map is regular by column (low nibble), so the 256 entries are
  // expressed as per-column rows indexed by the high nibble.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = op[7:4];
    lo = op[3:0];
    op_len = 2'd1;
    if (lo == 4'h1) begin
      op_len = 2'd2;                          // AJMP / ACALL
    end else if (lo >= 4'h6) begin            // @Ri and Rn columns
      case (hi)
        4'h7, 4'h8, 4'hA: op_len = 2'd2;
        4'hB:             op_len = 2'd3;
        4'hD:             op_len = (lo >= 4'h8) ? 2'd2 : 2'd1;
        default:          op_len = 2'd1;
      endcase
    end else begin
      case (lo)
        4'h0: begin
          case (hi)
            4'h1, 4'h2, 4'h3, 4'h9: op_len = 2'd3;
            4'h0, 4'hE, 4'hF:       op_len = 2'd1;
            default:                op_len = 2'd2;
          endcase
        end
        4'h2: begin
          case (hi)
            4'h0, 4'h1:             op_len = 2'd3;
            4'h2, 4'h3, 4'hE, 4'hF: op_len = 2'd1;
            default:                op_len = 2'd2;
          endcase
        end
        4'h3: begin
          case (hi)
            4'h4, 4'h5, 4'h6: op_len = 2'd3;
            default:          op_len = 2'd1;
          endcase
        end
        4'h4: begin
          case (hi)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: op_len = 2'd2;
            4'hB:                                     op_len = 2'd3;
            default:                                  op_len = 2'd1;
          endcase
        end
        4'h5: begin
          case (hi)
            4'h7, 4'h8, 4'hB, 4'hD: op_len = 2'd3;
            4'hA:                   op_len = 2'd1;
            default:                op_len = 2'd2;
          endcase
        end
        default: op_len = 2'd1;
      endcase
    end
  endfunction

endpackage

// File: rtl/inst_len_dec.sv
// inst_len_dec: combinational opcode -> instruction length lookup.
//   op  in  8  opcode byte
//   len out 2  instruction length, 1..3
module inst_len_dec
  import mcu51_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] len
);

  assign len = op_len(op);

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: byte-serial MCS-51 instruction fetch.
// Drives the program ROM one byte per cycle, assembles 1..3 byte
// instructions and hands them to the decoder over valid/ready.
//   clk, rst                    clock, synchronous active-high reset
//   rom_cs, rom_addr, rom_data  ROM port (cs active low, 1-cycle latency)
//   redirect_valid, redirect_pc flush and restart fetch
//   inst_valid, inst_ready      decoder handshake
//   inst_pc/op/b1/b2/len        assembled instruction
// Build option: IFU_LJMP_FOLLOW_EN makes fetch follow LJMP/SJMP by itself.
//
// state | meaning
// S_OP  | next byte is an opcode
// S_B1  | next byte is the second instruction byte
// S_B2  | next byte is the third instruction byte
// A completed instruction that cannot enter the output register is held in
// the assembly register with asm_done set (state is back at S_OP).
module inst_fetch_unit
  import mcu51_pkg::*;
#(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 rom_cs,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [ADDRWIDTH-1:0] inst_pc,
  output logic [7:0]           inst_op,
  output logic [7:0]           inst_b1,
  output logic [7:0]           inst_b2,
  output logic [1:0]           inst_len
);

  localparam logic [ADDRWIDTH-1:0] PC_ONE = ADDRWIDTH'(1);

  asm_state_e state, state_nx;

  logic [ADDRWIDTH-1:0] fetch_pc, byte_pc, byte_pc_nx;
  logic                 pend;
  logic [7:0]           pbyte;
  logic                 skid_valid, skid_valid_nx;
  logic [7:0]           skid_data, skid_data_nx;

  logic                 asm_done, asm_done_nx;
  logic [ADDRWIDTH-1:0] a_pc, a_pc_nx;
  logic [7:0]           a_op, a_op_nx, a_b1, a_b1_nx, a_b2, a_b2_nx;
  logic [1:0]           a_len, a_len_nx;

  logic                 src_valid, use_byte, out_free, complete, load;
  logic                 pend_left, stall, follow, issue;
  logic [7:0]           src_byte;
  logic [1:0]           dec_len;
  logic [ADDRWIDTH-1:0] follow_pc;

  // The skid byte is always older than the byte just captured from the ROM.
  assign src_valid = skid_valid | pend;
  assign src_byte  = skid_valid ? skid_data : pbyte;
  assign use_byte  = src_valid & ~asm_done;
  assign out_free  = ~inst_valid | inst_ready;

  inst_len_dec u_len_dec (
    .op  (src_byte),
    .len (dec_len)
  );

  always_comb begin
    state_nx = state;
    a_pc_nx  = a_pc;
    a_op_nx  = a_op;
    a_b1_nx  = a_b1;
    a_b2_nx  = a_b2;
    a_len_nx = a_len;
    complete = 1'b0;
    if (use_byte) begin
      case (state)
        S_OP: begin
          a_pc_nx  = byte_pc;
          a_op_nx  = src_byte;
          a_b1_nx  = 8'h00;
          a_b2_nx  = 8'h00;
          a_len_nx = dec_len;
          if (dec_len == 2'd1) complete = 1'b1;
          else                 state_nx = S_B1;
        end
        S_B1: begin
          a_b1_nx = src_byte;
          if (a_len == 2'd2) begin
            complete = 1'b1;
            state_nx = S_OP;
          end else begin
            state_nx = S_B2;
          end
        end
        S_B2: begin
          a_b2_nx  = src_byte;
          complete = 1'b1;
          state_nx = S_OP;
        end
        default: state_nx = S_OP;
      endcase
    end
  end

  // A finished instruction (new or waiting) moves to the output register
  // whenever that register is empty or being emptied this cycle.
  assign load        = (complete | asm_done) & out_free;
  assign asm_done_nx = (complete | asm_done) & ~out_free;
  assign byte_pc_nx  = use_byte ? byte_pc + PC_ONE : byte_pc;

  // The captured ROM byte lands in the skid unless it was consumed directly.
  assign pend_left     = pend & ~(use_byte & ~skid_valid);
  assign skid_valid_nx = pend_left | (skid_valid & ~use_byte);
  assign skid_data_nx  = pend_left ? pbyte : skid_data;

  // A byte issued now arrives next cycle; it can only be lost if the skid is
  // occupied and the assembly register is still blocked at that point.
  assign stall = skid_valid_nx & asm_done_nx;

`ifdef IFU_LJMP_FOLLOW_EN
  logic [ADDRWIDTH+15:0] ljmp_ext;
  logic [ADDRWIDTH+7:0]  rel_ext;
  assign ljmp_ext  = {{ADDRWIDTH{1'b0}}, a_b1_nx, a_b2_nx};
  assign rel_ext   = {{ADDRWIDTH{a_b1_nx[7]}}, a_b1_nx};
  assign follow    = complete & ((a_op_nx == OP_LJMP) | (a_op_nx == OP_SJMP));
  assign follow_pc = (a_op_nx == OP_LJMP) ? ljmp_ext[ADDRWIDTH-1:0]
                                          : a_pc_nx + ADDRWIDTH'(2) + rel_ext[ADDRWIDTH-1:0];
`else
  assign follow    = 1'b0;
  assign follow_pc = fetch_pc;
`endif

  assign issue    = ~rst & ~redirect_valid & ~follow & ~stall;
  assign rom_cs   = ~issue;
  assign rom_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OP;
      fetch_pc   <= '0;
      byte_pc    <= '0;
      pend       <= 1'b0;
      pbyte      <= 8'h00;
      skid_valid <= 1'b0;
      skid_data  <= 8'h00;
      asm_done   <= 1'b0;
      a_pc       <= '0;
      a_op       <= 8'h00;
      a_b1       <= 8'h00;
      a_b2       <= 8'h00;
      a_len      <= 2'd1;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      inst_op    <= 8'h00;
      inst_b1    <= 8'h00;
      inst_b2    <= 8'h00;
      inst_len   <= 2'd1;
    end else if (redirect_valid) begin
      state      <= S_OP;
      fetch_pc   <= redirect_pc;
      byte_pc    <= redirect_pc;
      pend       <= 1'b0;
      skid_valid <= 1'b0;
      asm_done   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      a_pc      <= a_pc_nx;
      a_op      <= a_op_nx;
      a_b1      <= a_b1_nx;
      a_b2      <= a_b2_nx;
      a_len     <= a_len_nx;
      asm_done  <= asm_done_nx;
      skid_data <= skid_data_nx;
      pend      <= issue;
      if (issue) pbyte <= rom_data;
      if (follow) begin
        fetch_pc   <= follow_pc;
        byte_pc    <= follow_pc;
        skid_valid <= 1'b0;
      end else begin
        fetch_pc   <= issue ? fetch_pc + PC_ONE : fetch_pc;
        byte_pc    <= byte_pc_nx;
        skid_valid <= skid_valid_nx;
      end
      if (load) begin
        inst_valid <= 1'b1;
        inst_pc    <= a_pc_nx;
        inst_op    <= a_op_nx;
        inst_b1    <= a_b1_nx;
        inst_b2    <= a_b2_nx;
        inst_len   <= a_len_nx;
      end else if (inst_ready) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule
